uart_rx_param: RTL

//   Parametrised UART receive engine with oversampled bit recovery and start-glitch rejection.

---
 rtl/uart_rx_param_if.sv | 31 +++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
// The receiver presents a held word with its error flags. The consumer accepts that word
// when rx_valid and rx_ready are both high.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output rx_dout,
    output rx_valid,
    output parity_err,
    output framing_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_dout,
    input  rx_valid,
    input  parity_err,
    input  framing_err,
    input  overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receive engine.
// - Data width, parity mode and stop-bit count are configurable.
// - A start bit that is high again at its mid-sample is rejected as a glitch.
// - Each word is handed on with its error flags through a valid/ready hold register.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_in,
  input  logic       rx_data,
  input  logic [1:0] parity_mode,
  input  logic       two_stop,
  output logic       busy,
  uart_rx_param_if.master rx_if
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 sync_reg [SYNC_STAGES];
  logic                 baud_prev_reg;
  logic                 tick_reg;
  logic                 rx_prev_reg;
  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [BW-1:0]        bit_reg;
  logic                 stop_second_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           par_mode_reg;
  logic                 two_stop_reg;
  logic                 perr_acc_reg;
  logic                 ferr_acc_reg;
  logic [DATA_BITS-1:0] dout_reg;
  logic                 valid_reg;
  logic                 perr_reg;
  logic                 ferr_reg;
  logic                 ovr_reg;

  logic rx_s;
  logic mid_tick;
  logic end_tick;
  logic par_en;
  logic final_stop;
  logic frame_ferr;
  logic accept;

  // Synchroniser chain for the asynchronous line. It is preset to idle-high so that reset
  // cannot fake a start edge.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw pin
        always_ff @(posedge clk) begin
          if (!reset) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= rx_data;
        end
      end else begin : g_rest
        // Later stages shift the sample along the chain
        always_ff @(posedge clk) begin
          if (!reset) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s       = sync_reg[SYNC_STAGES-1];
  assign mid_tick   = tick_reg && (cnt_reg == CNT_MID);
  assign end_tick   = tick_reg && (cnt_reg == CNT_END);
  assign par_en     = (par_mode_reg == 2'b01) || (par_mode_reg == 2'b10);
  assign final_stop = (state_reg == STOP) && mid_tick && (!two_stop_reg || stop_second_reg);
  assign frame_ferr = ferr_acc_reg | ~rx_s;
  assign accept     = valid_reg & rx_if.rx_ready;

  // Turn each rising edge of the baud strobe into a one-clock tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_prev_reg <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      baud_prev_reg <= baud_in;
      tick_reg      <= baud_in & ~baud_prev_reg;
    end
  end

  // Frame state machine and output hold register. A completed frame loads straight into the
  // hold register on its final stop mid-sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      rx_prev_reg     <= 1'b1;
      cnt_reg         <= '0;
      bit_reg         <= '0;
      stop_second_reg <= 1'b0;
      shift_reg       <= '0;
      par_mode_reg    <= 2'b00;
      two_stop_reg    <= 1'b0;
      perr_acc_reg    <= 1'b0;
      ferr_acc_reg    <= 1'b0;
      dout_reg        <= '0;
      valid_reg       <= 1'b0;
      perr_reg        <= 1'b0;
      ferr_reg        <= 1'b0;
      ovr_reg         <= 1'b0;
    end else begin
      rx_prev_reg <= rx_s;
      if (state_reg != IDLE && tick_reg)
        cnt_reg <= (cnt_reg == CNT_END) ? '0 : cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_s) begin
            state_reg       <= START;
            cnt_reg         <= '0;
            bit_reg         <= '0;
            stop_second_reg <= 1'b0;
            perr_acc_reg    <= 1'b0;
            ferr_acc_reg    <= 1'b0;
            par_mode_reg    <= parity_mode;
            two_stop_reg    <= two_stop;
          end
        end
        START: begin
          if (mid_tick && rx_s) state_reg <= IDLE;
          else if (end_tick)    state_reg <= DATA;
        end
        DATA: begin
          if (mid_tick) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
          if (end_tick) begin
            if (bit_reg == BIT_LAST) state_reg <= par_en ? PARITY : STOP;
            else                     bit_reg   <= bit_reg + 1'b1;
          end
        end
        PARITY: begin
          if (mid_tick)
            perr_acc_reg <= (par_mode_reg == 2'b01) ? (^shift_reg ^ rx_s) : ~(^shift_reg ^ rx_s);
          if (end_tick) state_reg <= STOP;
        end
        STOP: begin
          if (final_stop) begin
            state_reg <= rx_s ? IDLE : BREAK;
          end else begin
            if (mid_tick) ferr_acc_reg    <= ferr_acc_reg | ~rx_s;
            if (end_tick) stop_second_reg <= 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // A new word may replace one being accepted this cycle. The new word is dropped only
      // while the old one is still refused.
      if (final_stop) begin
        if (!valid_reg || rx_if.rx_ready) begin
          dout_reg  <= shift_reg;
          valid_reg <= 1'b1;
          perr_reg  <= perr_acc_reg;
          ferr_reg  <= frame_ferr;
          ovr_reg   <= 1'b0;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (accept) begin
        valid_reg <= 1'b0;
        perr_reg  <= 1'b0;
        ferr_reg  <= 1'b0;
        ovr_reg   <= 1'b0;
      end
    end
  end

  assign busy              = (state_reg != IDLE);
  assign rx_if.rx_dout     = dout_reg;
  assign rx_if.rx_valid    = valid_reg;
  assign rx_if.parity_err  = perr_reg;
  assign rx_if.framing_err = ferr_reg;
  assign rx_if.overrun_err = ovr_reg;
endmodule
